// File: rtl/arb_pkg.sv
// Shared types and limits for the unified instruction/data memory arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_WAIT = 2'd1,
      D_WAIT = 2'd2
   } arb_state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int MEM_LAT_MIN    = 1;
   localparam int MEM_LAT_MAX    = 4;
   localparam int STARVE_MAX_MIN = 1;
   localparam int STARVE_MAX_MAX = 15;

   // Out-of-range parameters are pulled back into the legal range instead of
   // producing counters that never match.
   function automatic int clamp_int(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module perf_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch / load-store arbiter in front of one fixed-latency single-port SRAM.
// Define ARB_PERF_CNT_EN to add saturating stall/conflict performance counters.
module unified_mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]         perf_i_stall,
   output logic [31:0]         perf_d_stall,
   output logic [31:0]         perf_conflict
`endif
);

   localparam int         LAT_C    = clamp_int(MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX);
   localparam logic [1:0] LAT_INIT = 2'(LAT_C - 1);
   localparam logic [3:0] STARVE_C = 4'(clamp_int(STARVE_MAX, STARVE_MAX_MIN, STARVE_MAX_MAX));

   arb_state_t state_q, state_d;
   logic [1:0] lat_cnt_q, lat_cnt_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;

   logic grant_en;
   logic fetch_forced;
   logic owner;

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      owner        = OWN_I;

      // Grants are gated by rst so every output is 0 while reset is held.
      grant_en     = (state_q == IDLE) && !rst;
      fetch_forced = i_req && (starve_cnt_q == STARVE_C);
      d_gnt        = grant_en && d_req && !fetch_forced;
      i_gnt        = grant_en && i_req && !d_gnt;
      if (d_gnt) begin
         owner = OWN_D;
      end

      mem_req   = i_gnt | d_gnt;
      mem_we    = d_gnt & d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (mem_req) begin
         mem_addr = (owner == OWN_D) ? d_addr : i_addr;
         if (owner == OWN_D) begin
            mem_wdata = d_wdata;
            mem_be    = d_be;
         end
      end

      i_rvalid = (state_q == I_WAIT) && (lat_cnt_q == 2'd0);
      d_rvalid = (state_q == D_WAIT) && (lat_cnt_q == 2'd0);
      i_rdata  = i_rvalid ? mem_rdata : '0;
      d_rdata  = d_rvalid ? mem_rdata : '0;

      unique case (state_q)
         IDLE: begin
            if (d_gnt && !d_we) begin
               state_d   = D_WAIT;
               lat_cnt_d = LAT_INIT;
            end else if (i_gnt) begin
               state_d   = I_WAIT;
               lat_cnt_d = LAT_INIT;
            end
         end
         I_WAIT, D_WAIT: begin
            if (lat_cnt_q == 2'd0) begin
               state_d = IDLE;
            end else begin
               lat_cnt_d = lat_cnt_q - 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!i_req || i_gnt) begin
         starve_cnt_d = 4'd0;
      end else if (d_gnt && (starve_cnt_q != STARVE_C)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         lat_cnt_q    <= 2'd0;
         starve_cnt_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

`ifdef ARB_PERF_CNT_EN
   perf_sat_counter #(.W(32)) u_perf_i_stall (
      .clk   (clk),
      .rst   (rst),
      .inc   (i_req && !i_gnt),
      .count (perf_i_stall)
   );

   perf_sat_counter #(.W(32)) u_perf_d_stall (
      .clk   (clk),
      .rst   (rst),
      .inc   (d_req && !d_gnt),
      .count (perf_d_stall)
   );

   perf_sat_counter #(.W(32)) u_perf_conflict (
      .clk   (clk),
      .rst   (rst),
      .inc   ((state_q == IDLE) && i_req && d_req),
      .count (perf_conflict)
   );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (MEM_LAT=2, STARVE_MAX=4) with a
// small byte-enabled memory model behind the arbiter.
module tb_unified_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_i_stall;
   logic [31:0] perf_d_stall;
   logic [31:0] perf_conflict;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   unified_mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MEM_LAT    (2),
      .STARVE_MAX (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt),
      .i_rvalid  (i_rvalid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_i_stall  (perf_i_stall),
      .perf_d_stall  (perf_d_stall),
      .perf_conflict (perf_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: two-stage read pipeline gives data 2 cycles after mem_req.
   logic [31:0] mem [0:255];
   logic [31:0] pipe1;
   logic [31:0] pipe2;

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = 32'hFFFF_FFFF;
      mem[8'h04] = 32'hDEAD_BEEF;   // 0x010
      mem[8'h08] = 32'h1111_2222;   // 0x020
      mem[8'h80] = 32'hCAFE_F00D;   // 0x200
      pipe1 = 32'h0;
      pipe2 = 32'h0;
   end

   always @(posedge clk) begin
      if (mem_req && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      pipe1 <= (mem_req && !mem_we) ? mem[mem_addr[9:2]] : 32'h0;
      pipe2 <= pipe1;
   end

   assign mem_rdata = pipe2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b1; i_addr = 32'h10;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;

      // Reset: outputs held at 0 even with a request present
      @(negedge clk); #1;
      chk("rst_i_gnt", 64'(i_gnt), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_i_rvalid", 64'(i_rvalid), 64'd0);
      @(negedge clk); i_req = 1'b0; rst = 1'b0; #1;
      chk("idle_mem_req", 64'(mem_req), 64'd0);

      // Single fetch, latency 2, next grant at T+3
      @(negedge clk); i_req = 1'b1; i_addr = 32'h10; #1;
      chk("t1_i_gnt", 64'(i_gnt), 64'd1);
      chk("t1_mem_addr", 64'(mem_addr), 64'h10);
      chk("t1_mem_we", 64'(mem_we), 64'd0);
      @(negedge clk); #1;
      chk("t1_wait_gnt", 64'(i_gnt), 64'd0);
      chk("t1_wait_memreq", 64'(mem_req), 64'd0);
      chk("t1_early_rvalid", 64'(i_rvalid), 64'd0);
      @(negedge clk); #1;
      chk("t1_rvalid", 64'(i_rvalid), 64'd1);
      chk("t1_rdata", 64'(i_rdata), 64'hDEAD_BEEF);
      chk("t1_rv_cycle_gnt", 64'(i_gnt), 64'd0);
      @(negedge clk); #1;
      chk("t1_regrant", 64'(i_gnt), 64'd1);
      @(negedge clk); i_req = 1'b0; #1;
      @(negedge clk); #1;
      chk("t1b_rvalid", 64'(i_rvalid), 64'd1);

      // Both requests: data load wins, fetch follows after its rvalid
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; #1;
      chk("t2_d_gnt", 64'(d_gnt), 64'd1);
      chk("t2_i_gnt", 64'(i_gnt), 64'd0);
      chk("t2_mem_addr", 64'(mem_addr), 64'h200);
      @(negedge clk); d_req = 1'b0; #1;
      chk("t2_wait_d_gnt", 64'(d_gnt), 64'd0);
      @(negedge clk); #1;
      chk("t2_d_rvalid", 64'(d_rvalid), 64'd1);
      chk("t2_d_rdata", 64'(d_rdata), 64'hCAFE_F00D);
      chk("t2_i_rdata_zero", 64'(i_rdata), 64'd0);
      chk("t2_rv_i_gnt", 64'(i_gnt), 64'd0);
      @(negedge clk); #1;
      chk("t2_i_gnt_after", 64'(i_gnt), 64'd1);
      chk("t2_i_mem_addr", 64'(mem_addr), 64'h20);
      chk("t2_d_rdata_zero", 64'(d_rdata), 64'd0);
      @(negedge clk); i_req = 1'b0; #1;
      @(negedge clk); #1;
      chk("t2_i_rdata", 64'(i_rdata), 64'h1111_2222);

      // Starvation: four store grants, then the fetch is forced through
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h5555_AAAA; d_be = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("t3_d_gnt_%0d", k), 64'(d_gnt), 64'd1);
         chk($sformatf("t3_i_gnt_%0d", k), 64'(i_gnt), 64'd0);
         @(negedge clk);
      end
      #1;
      chk("t3_forced_i_gnt", 64'(i_gnt), 64'd1);
      chk("t3_forced_d_gnt", 64'(d_gnt), 64'd0);
      @(negedge clk); i_req = 1'b0; d_req = 1'b0; #1;
      @(negedge clk); #1;
      chk("t3_i_rvalid", 64'(i_rvalid), 64'd1);
      @(negedge clk); i_req = 1'b1; d_req = 1'b1; #1;
      chk("t3_starve_cleared", 64'(d_gnt), 64'd1);
      @(negedge clk); i_req = 1'b0; d_req = 1'b0; #1;

      // Three back-to-back partial stores, then read one back
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h80; d_wdata = 32'hAABB_CCDD; #1;
      chk("t4_s0_gnt", 64'(d_gnt), 64'd1);
      chk("t4_s0_we", 64'(mem_we), 64'd1);
      chk("t4_s0_be", 64'(mem_be), 64'h3);
      @(negedge clk); d_addr = 32'h84; d_wdata = 32'h1234_5678; #1;
      chk("t4_s1_gnt", 64'(d_gnt), 64'd1);
      chk("t4_s1_be", 64'(mem_be), 64'h3);
      chk("t4_s1_wdata", 64'(mem_wdata), 64'h1234_5678);
      @(negedge clk); d_addr = 32'h88; d_wdata = 32'h9ABC_DEF0; #1;
      chk("t4_s2_gnt", 64'(d_gnt), 64'd1);
      chk("t4_s2_we", 64'(mem_we), 64'd1);
      chk("t4_s2_rvalid", 64'(d_rvalid), 64'd0);
      @(negedge clk); d_req = 1'b0; #1;
      chk("t4_no_rvalid", 64'(d_rvalid), 64'd0);
      @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84; #1;
      chk("t4_rd_gnt", 64'(d_gnt), 64'd1);
      @(negedge clk); d_req = 1'b0; #1;
      @(negedge clk); #1;
      chk("t4_rd_data", 64'(d_rdata), 64'hFFFF_5678);

      // Withdrawn data request during a fetch wait is ignored
      @(negedge clk); i_req = 1'b1; i_addr = 32'h10; #1;
      chk("t5_i_gnt", 64'(i_gnt), 64'd1);
      @(negedge clk); i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; #1;
      chk("t5_wait_d_gnt", 64'(d_gnt), 64'd0);
      @(negedge clk); d_req = 1'b0; #1;
      @(negedge clk); #1;
      chk("t5_withdrawn_req", 64'(mem_req), 64'd0);
      @(negedge clk); #1;
      chk("t5_no_d_rvalid", 64'(d_rvalid), 64'd0);

      // Reset mid-wait aborts the read; a fresh request is then granted
      @(negedge clk); i_req = 1'b1; i_addr = 32'h10; #1;
      chk("t6_i_gnt", 64'(i_gnt), 64'd1);
      @(negedge clk); rst = 1'b1; #1;
      chk("t6_rst_i_gnt", 64'(i_gnt), 64'd0);
      chk("t6_rst_mem_req", 64'(mem_req), 64'd0);
      chk("t6_rst_i_rvalid", 64'(i_rvalid), 64'd0);
      @(negedge clk); #1;
      chk("t6_rst_no_rvalid", 64'(i_rvalid), 64'd0);
      @(negedge clk); rst = 1'b0; #1;
      chk("t6_post_rst_gnt", 64'(i_gnt), 64'd1);
      @(negedge clk); i_req = 1'b0; #1;
      chk("t6_wait_rvalid", 64'(i_rvalid), 64'd0);
      @(negedge clk); #1;
      chk("t6_rvalid", 64'(i_rvalid), 64'd1);
      chk("t6_rdata", 64'(i_rdata), 64'hDEAD_BEEF);

`ifdef ARB_PERF_CNT_EN
      // Ten cycles of fetch blocked by back-to-back loads
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      repeat (10) @(negedge clk);
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      chk("perf_i_stall", 64'(perf_i_stall), 64'd10);
      chk("perf_d_stall", 64'(perf_d_stall), 64'd6);
      chk("perf_conflict", 64'(perf_conflict), 64'd4);
`endif

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
